mdr_mem_if: RTL and testbench

MDR_MEM_IF -- requirements
Module: mdr_mem_if

---
 rtl/mdr_mem_if.sv | 141 ++++++++++++++
 tb/tb_mdr_mem_if.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdr_mem_if.sv
// mdr_mem_if: memory data register with a single-outstanding memory handshake.
// A read or write request launches one access and the block waits for mem_ack.
// MDR can also be loaded directly from the datapath bus while idle.
// Optional feature macro: MDR_TIMEOUT_EN adds a wait counter and a sticky
// timeout flag (err). Without it the block waits for ack indefinitely.
module mdr_mem_if #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       BusMuxOut,
  input  logic              MDRin,
  input  logic [ADDR_W-1:0] mar,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [31:0]       BusMuxIn_MDR,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    WR_WAIT = 2'b10
  } state_t;

  // The wait counter is 8 bits wide, so TIMEOUT must fit in 1..255.
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : gBadTimeout
    $error("mdr_mem_if: TIMEOUT must be within 1..255");
  end

  state_t      state_r;
  logic [31:0] mdr_r;

  // The bus mux always sees the register itself; no extra latency.
  assign BusMuxIn_MDR = mdr_r;

`ifdef MDR_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  logic [7:0] waitCnt_r;
`else
  assign err = 1'b0;
`endif

  // Access FSM: request acceptance, wait for ack (or timeout), MDR loads.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r   <= IDLE;
      mdr_r     <= 32'h0000_0000;
      mem_addr  <= '0;
      mem_wdata <= 32'h0000_0000;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef MDR_TIMEOUT_EN
      waitCnt_r <= 8'd0;
      err       <= 1'b0;
`endif
    end else begin
      // done is a single-cycle pulse; only the ack branch raises it.
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          // Priority: rd_req, then wr_req, then MDRin; losers are dropped.
          if (rd_req) begin
            state_r  <= RD_WAIT;
            mem_addr <= mar;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
`ifdef MDR_TIMEOUT_EN
            waitCnt_r <= 8'd0;
            err       <= 1'b0;
`endif
          end else if (wr_req) begin
            state_r   <= WR_WAIT;
            mem_addr  <= mar;
            mem_wdata <= mdr_r;
            mem_wr    <= 1'b1;
            busy      <= 1'b1;
`ifdef MDR_TIMEOUT_EN
            waitCnt_r <= 8'd0;
            err       <= 1'b0;
`endif
          end else if (MDRin) begin
            mdr_r <= BusMuxOut;
          end else begin
            mdr_r <= mdr_r;
          end
        end
        RD_WAIT, WR_WAIT: begin
          // Requests and MDRin are ignored here; address/data/strobe hold.
          if (mem_ack) begin
            if (state_r == RD_WAIT) begin
              mdr_r <= mem_rdata;
            end else begin
              mdr_r <= mdr_r;
            end
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= IDLE;
`ifdef MDR_TIMEOUT_EN
          end else if (waitCnt_r == (TIMEOUT_C - 8'd1)) begin
            // This cycle the counter reaches TIMEOUT: give up, no done pulse.
            waitCnt_r <= waitCnt_r + 8'd1;
            err       <= 1'b1;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            waitCnt_r <= waitCnt_r + 8'd1;
          end
`else
          end else begin
            state_r <= state_r;
          end
`endif
        end
        default: begin
          // Unreachable encoding: recover to a quiet idle.
          state_r <= IDLE;
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_mem_if.sv
// Self-checking bench for mdr_mem_if: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_mdr_mem_if;

  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              clr;
  logic [31:0]       BusMuxOut;
  logic              MDRin;
  logic [ADDR_W-1:0] mar;
  logic              rd_req;
  logic              wr_req;
  logic [31:0]       BusMuxIn_MDR;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              busy;
  logic              done;
  logic              err;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: one pending access at a time, described as a record.
  logic [31:0]       mMdr;
  logic [ADDR_W-1:0] mAddr;
  logic [31:0]       mWdata;
  logic              mPending;
  logic              mIsRead;
  logic              mDone;
  logic              mErr;
  int                mWaits;

  mdr_mem_if #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .MDRin(MDRin), .mar(mar),
    .rd_req(rd_req), .wr_req(wr_req), .BusMuxIn_MDR(BusMuxIn_MDR),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMdr = 32'h0; mAddr = '0; mWdata = 32'h0;
    mPending = 1'b0; mIsRead = 1'b0; mDone = 1'b0; mErr = 1'b0; mWaits = 0;
  endtask

  // What one clock edge does, in terms of accesses rather than states.
  task automatic modelEdge();
    mDone = 1'b0;
    if (!mPending) begin
      if (rd_req || wr_req) begin
        mPending = 1'b1;
        mIsRead  = rd_req;
        mAddr    = mar;
        if (!rd_req) mWdata = mMdr;
        mWaits   = 0;
        mErr     = 1'b0;
      end else if (MDRin) begin
        mMdr = BusMuxOut;
      end
    end else if (mem_ack) begin
      if (mIsRead) mMdr = mem_rdata;
      mPending = 1'b0;
      mDone    = 1'b1;
    end else begin
      mWaits++;
`ifdef MDR_TIMEOUT_EN
      if (mWaits == TIMEOUT) begin
        mPending = 1'b0;
        mErr     = 1'b1;
      end
`endif
    end
  endtask

  task automatic checkAll(input string tag);
    logic [4:0] expFlags;
    expFlags = {mPending && mIsRead, mPending && !mIsRead, mPending, mDone, mErr};
    checkVal({tag, ".mdr"},   {32'h0, BusMuxIn_MDR}, {32'h0, mMdr});
    checkVal({tag, ".addr"},  {55'h0, mem_addr},     {55'h0, mAddr});
    checkVal({tag, ".wdata"}, {32'h0, mem_wdata},    {32'h0, mWdata});
    checkVal({tag, ".flags"}, {59'h0, mem_rd, mem_wr, busy, done, err}, {59'h0, expFlags});
  endtask

  // One clock edge: model follows the held inputs, outputs checked after it.
  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    modelEdge();
    checkAll(tag);
  endtask

  task automatic idleInputs();
    rd_req = 1'b0; wr_req = 1'b0; MDRin = 1'b0; mem_ack = 1'b0;
  endtask

  // Asynchronous clear pulse placed between clock edges.
  task automatic pulseClr(input string tag);
    #2;
    clr = 1'b1;
    #1;
    modelReset();
    checkAll(tag);
    clr = 1'b0;
    #1;
  endtask

  initial begin : stim
    int rdCycles;
    clr = 1'b1; BusMuxOut = 32'h0; mar = '0; mem_rdata = 32'h0;
    idleInputs();
    modelReset();
    #12;
    checkAll("reset");
    #1;
    clr = 1'b0;

    // MDRin load: value on the bus mux the next cycle, not busy.
    MDRin = 1'b1; BusMuxOut = 32'hDEAD_BEEF;
    tick("load");
    idleInputs();
    checkVal("load_value", {32'h0, BusMuxIn_MDR}, 64'hDEAD_BEEF);
    checkVal("load_busy", {63'h0, busy}, 64'h0);

    // Read at 0x05, ack sampled three edges after the request.
    rd_req = 1'b1; mar = 9'h005; mem_rdata = 32'h1234_5678;
    rdCycles = 0;
    tick("rd0"); idleInputs(); rdCycles += int'(mem_rd);
    tick("rd1"); rdCycles += int'(mem_rd);
    tick("rd2"); rdCycles += int'(mem_rd);
    mem_ack = 1'b1;
    tick("rd3"); rdCycles += int'(mem_rd);
    mem_ack = 1'b0;
    checkVal("rd_strobe_cycles", 64'(rdCycles), 64'd3);
    checkVal("rd_done", {63'h0, done}, 64'h1);
    checkVal("rd_mdr", {32'h0, BusMuxIn_MDR}, 64'h1234_5678);
    tick("rd4");
    checkVal("rd_done_once", {63'h0, done}, 64'h0);

    // Write of 0xA5A5A5A5 to 0x1FF with the minimum two-edge access.
    MDRin = 1'b1; BusMuxOut = 32'hA5A5_A5A5;
    tick("wrload"); idleInputs();
    wr_req = 1'b1; mar = 9'h1FF;
    tick("wr0"); idleInputs();
    checkVal("wr_wdata", {32'h0, mem_wdata}, 64'hA5A5_A5A5);
    checkVal("wr_strobe", {63'h0, mem_wr}, 64'h1);
    mem_ack = 1'b1;
    tick("wr1"); idleInputs();
    checkVal("wr_done", {62'h0, done, mem_wr}, 64'h2);
    tick("wr2");

    // All three requests together: only the read happens.
    rd_req = 1'b1; wr_req = 1'b1; MDRin = 1'b1; mar = 9'h033;
    BusMuxOut = 32'h0BAD_F00D; mem_rdata = 32'h5555_AAAA;
    tick("pri0"); idleInputs();
    checkVal("pri_mdr_held", {32'h0, BusMuxIn_MDR}, 64'hA5A5_A5A5);
    checkVal("pri_read_only", {62'h0, mem_rd, mem_wr}, 64'h2);
    tick("pri1");
    mem_ack = 1'b1;
    tick("pri2"); idleInputs();
    checkVal("pri_mdr_ack", {32'h0, BusMuxIn_MDR}, 64'h5555_AAAA);

    // Long stall with no ack; the timeout build gives up, the default waits.
    rd_req = 1'b1; mar = 9'h0AA;
    tick("to0"); idleInputs();
    for (int i = 0; i < TIMEOUT + 3; i++) tick("to_wait");
`ifdef MDR_TIMEOUT_EN
    checkVal("to_err", {62'h0, err, busy}, 64'h2);
`else
    checkVal("to_still_busy", {62'h0, err, busy}, 64'h1);
    mem_ack = 1'b1;
    tick("to_ack"); idleInputs();
`endif
    rd_req = 1'b1; mar = 9'h0AB;
    tick("to_clear"); idleInputs();
    checkVal("to_err_cleared", {63'h0, err}, 64'h0);
    mem_ack = 1'b1;
    tick("to_done"); idleInputs();

    // Clear in the middle of a read, then a stray ack that must be ignored.
    rd_req = 1'b1; mar = 9'h077; mem_rdata = 32'hFFFF_0000;
    tick("clr0"); idleInputs();
    tick("clr1");
    pulseClr("clr_mid");
    checkVal("clr_outputs", {busy, mem_rd, done, err, BusMuxIn_MDR}, 64'h0);
    mem_ack = 1'b1;
    tick("clr_ack"); idleInputs();
    checkVal("clr_no_done", {63'h0, done}, 64'h0);

    // Randomized traffic with occasional asynchronous clears.
    for (int i = 0; i < 3000; i++) begin
      rd_req    = ($urandom_range(0, 7) == 0);
      wr_req    = ($urandom_range(0, 7) == 0);
      MDRin     = ($urandom_range(0, 3) == 0);
      mem_ack   = ($urandom_range(0, 2) == 0);
      mar       = ADDR_W'($urandom);
      BusMuxOut = $urandom;
      mem_rdata = $urandom;
      tick("rand");
      if ($urandom_range(0, 199) == 0) pulseClr("rand_clr");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
